move_sequencer: RTL

Command-driven step/dir sequencer for the motor channel inside rapcore. It sits between the SPI command decoder and the STEPOUTPUT/DIROUTPUT pads. Moves are queued in a small FIFO, each holding a direction, a step count and a step period. The block plays the moves back as timed step pulses, with direction setup time, move-complete strobes, buffer-ready flow control and a HALT abort.

---
 rtl/move_sequencer.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Step/dir move sequencer: queues {dir, steps, period} commands and plays them out as timed step pulses.
// Optional build macro MOVE_SEQ_ACCEL_EN adds a per-move signed period increment (cmd_accel).
module move_sequencer #(
    parameter int DEPTH     = 4,
    parameter int STEPS_W   = 32,
    parameter int TICK_W    = 16,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic [TICK_W-1:0]  cmd_period,
`ifdef MOVE_SEQ_ACCEL_EN
    input  logic [TICK_W-1:0]  cmd_accel,
`endif
    input  logic               halt,
    output logic               step_out,
    output logic               dir_out,
    output logic               move_done,
    output logic               buffer_dtr,
    output logic               busy,
    output logic [STEPS_W-1:0] position
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     FULL_CNT   = CW'(DEPTH);
    localparam logic [TICK_W-1:0] MIN_PERIOD = TICK_W'(2 * PULSE_W);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_DIR_SETUP = 3'd2,
        S_STEP_HI   = 3'd3,
        S_STEP_LO   = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    function automatic logic [TICK_W-1:0] clamp_period(input logic [TICK_W-1:0] p);
        if (p < MIN_PERIOD) begin
            return MIN_PERIOD;
        end else begin
            return p;
        end
    endfunction

`ifdef MOVE_SEQ_ACCEL_EN
    function automatic logic [TICK_W-1:0] accel_period(input logic [TICK_W-1:0] p,
                                                      input logic [TICK_W-1:0] a);
        logic signed [TICK_W+1:0] sum;
        sum = $signed({2'b00, p}) + $signed({{2{a[TICK_W-1]}}, a});
        if (sum < $signed({2'b00, MIN_PERIOD})) begin
            return MIN_PERIOD;
        end else if (sum > $signed({2'b00, {TICK_W{1'b1}}})) begin
            return {TICK_W{1'b1}};
        end else begin
            return sum[TICK_W-1:0];
        end
    endfunction
`endif

    logic               mem_dir_r    [DEPTH];
    logic [STEPS_W-1:0] mem_steps_r  [DEPTH];
    logic [TICK_W-1:0]  mem_period_r [DEPTH];
`ifdef MOVE_SEQ_ACCEL_EN
    logic [TICK_W-1:0]  mem_accel_r  [DEPTH];
    logic [TICK_W-1:0]  move_accel_r;
`endif
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      count_r, count_next_s;

    logic               halt_meta_r, halt_sync_r;
    state_t             state_r, next_state_s;
    logic [TICK_W-1:0]  tick_r;
    logic               move_dir_r;
    logic [STEPS_W-1:0] remaining_r;
    logic [TICK_W-1:0]  eff_period_r;

    logic               step_out_r, dir_out_r, move_done_r, buffer_dtr_r, busy_r, cmd_ready_r;
    logic [STEPS_W-1:0] position_r;

    logic push_s, pop_s, empty_s, done_s, dir_load_s, tick_clr_s, step_end_s, rise_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = cmd_valid && cmd_ready_r && !halt_sync_r;
    assign rise_s  = (state_r == S_STEP_HI) && (tick_r == {TICK_W{1'b0}}) && !halt_sync_r;

    // Two-flop synchronizer for the asynchronous halt pad.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            halt_meta_r <= 1'b0;
            halt_sync_r <= 1'b0;
        end else begin
            halt_meta_r <= halt;
            halt_sync_r <= halt_meta_r;
        end
    end

    // Next FIFO occupancy; halt flushes and overrides any push or pop.
    always_comb begin
        count_next_s = count_r;
        if (halt_sync_r) begin
            count_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (halt_sync_r) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_next_s;
        end
    end

    // FIFO storage; contents are only meaningful below count_r so no reset is needed.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_dir_r[wr_ptr_r]    <= cmd_dir;
            mem_steps_r[wr_ptr_r]  <= cmd_steps;
            mem_period_r[wr_ptr_r] <= cmd_period;
`ifdef MOVE_SEQ_ACCEL_EN
            mem_accel_r[wr_ptr_r]  <= cmd_accel;
`endif
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        dir_load_s   = 1'b0;
        tick_clr_s   = 1'b0;
        step_end_s   = 1'b0;
        if (halt_sync_r) begin
            next_state_s = S_HALTED;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (enable && !empty_s) begin
                        next_state_s = S_LOAD;
                        pop_s        = 1'b1;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    tick_clr_s = 1'b1;
                    if (remaining_r == {STEPS_W{1'b0}}) begin
                        done_s       = 1'b1;
                        next_state_s = S_IDLE;
                    end else if (move_dir_r != dir_out_r) begin
                        dir_load_s   = 1'b1;
                        next_state_s = S_DIR_SETUP;
                    end else begin
                        next_state_s = S_STEP_HI;
                    end
                end
                S_DIR_SETUP: begin
                    if (tick_r == TICK_W'(DIR_SETUP - 1)) begin
                        tick_clr_s   = 1'b1;
                        next_state_s = S_STEP_HI;
                    end else begin
                        next_state_s = S_DIR_SETUP;
                    end
                end
                S_STEP_HI: begin
                    if (tick_r == TICK_W'(PULSE_W - 1)) begin
                        next_state_s = S_STEP_LO;
                    end else begin
                        next_state_s = S_STEP_HI;
                    end
                end
                S_STEP_LO: begin
                    // tick_r keeps counting from the rising edge, so this ends the full period
                    if (tick_r == eff_period_r - TICK_W'(1)) begin
                        step_end_s = 1'b1;
                        if (remaining_r == STEPS_W'(1)) begin
                            done_s = 1'b1;
                            if (enable && !empty_s) begin
                                pop_s        = 1'b1;
                                next_state_s = S_LOAD;
                            end else begin
                                next_state_s = S_IDLE;
                            end
                        end else begin
                            tick_clr_s   = 1'b1;
                            next_state_s = S_STEP_HI;
                        end
                    end else begin
                        next_state_s = S_STEP_LO;
                    end
                end
                S_HALTED: begin
                    next_state_s = S_IDLE;
                end
                default: begin
                    next_state_s = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register and phase counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= S_IDLE;
            tick_r  <= {TICK_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            tick_r  <= tick_clr_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
        end
    end

    // Active move registers, loaded from the FIFO head on pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            move_dir_r   <= 1'b0;
            remaining_r  <= {STEPS_W{1'b0}};
            eff_period_r <= MIN_PERIOD;
`ifdef MOVE_SEQ_ACCEL_EN
            move_accel_r <= {TICK_W{1'b0}};
`endif
        end else if (pop_s) begin
            move_dir_r   <= mem_dir_r[rd_ptr_r];
            remaining_r  <= mem_steps_r[rd_ptr_r];
            eff_period_r <= clamp_period(mem_period_r[rd_ptr_r]);
`ifdef MOVE_SEQ_ACCEL_EN
            move_accel_r <= mem_accel_r[rd_ptr_r];
`endif
        end else if (step_end_s) begin
            remaining_r  <= remaining_r - STEPS_W'(1);
`ifdef MOVE_SEQ_ACCEL_EN
            eff_period_r <= accel_period(eff_period_r, move_accel_r);
`endif
        end
    end

    // Registered outputs; step_out trails the STEP_HI state by one cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            step_out_r   <= 1'b0;
            dir_out_r    <= 1'b0;
            move_done_r  <= 1'b0;
            busy_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
            buffer_dtr_r <= 1'b1;
            position_r   <= {STEPS_W{1'b0}};
        end else begin
            step_out_r   <= (state_r == S_STEP_HI) && !halt_sync_r;
            dir_out_r    <= dir_load_s ? move_dir_r : dir_out_r;
            move_done_r  <= done_s;
            busy_r       <= (next_state_s != S_IDLE) && (next_state_s != S_HALTED);
            cmd_ready_r  <= (count_next_s != FULL_CNT) && (next_state_s != S_HALTED);
            buffer_dtr_r <= (count_next_s != FULL_CNT);
            if (rise_s) begin
                position_r <= move_dir_r ? position_r + STEPS_W'(1) : position_r - STEPS_W'(1);
            end
        end
    end

    assign step_out   = step_out_r;
    assign dir_out    = dir_out_r;
    assign move_done  = move_done_r;
    assign busy       = busy_r;
    assign cmd_ready  = cmd_ready_r;
    assign buffer_dtr = buffer_dtr_r;
    assign position   = position_r;

endmodule
